jamma_input_scanner: RTL and testbench
======================================

Name: jamma_input_scanner

Overview:
Sequences the shared JAMMA joystick splitter: drives JSELECT, waits a settle time after each switch, samples the shared 8-bit JJOY bus once per player slot, and debounces each bit. Also debounces JCOIN and turns each coin press into a fixed-width coin pulse. Sits in the arcade top level, between the JAMMA pins and keyboard joystick on one side and the game core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs on the other.

Parameters:
SETTLE_CYC, 8, CLK cycles JSELECT is held before sampling; legal range 1..255.
DEB_SAMPLES, 3, consecutive equal samples needed to change a debounced bit; legal range 1..15. 1 means no filtering.
COIN_PULSE, 16, active-low coin pulse width in CLK cycles; legal range 1..65535.

Ports:
CLK  in  1  pixel clock (pclk domain).
RESET  in  1  asynchronous, active-high reset.
JJOY  in  8  shared JAMMA joystick bus, active-low: [5:0] directions/fire, [7] start.
JCOIN  in  2  JAMMA coin inputs, active-low, asynchronous to CLK.
KBD_JOY  in  6  keyboard joystick, active-low; ANDed into player 1 bits [5:0].
JSELECT  out  1  splitter select: 0 = player 1, 1 = player 2.
JOY1  out  8  debounced player 1, active-low.
JOY2  out  8  debounced player 2, active-low.
COIN_N  out  2  coin pulses to the core, active-low.
SCAN_DONE  out  1  one-cycle strobe when a full P1+P2 scan has been applied.

Behaviour:
- Reset (asynchronous, any time, including mid-scan): state S_P1_SET, settle counter 0, JSELECT=0, JOY1=JOY2=8'hFF, COIN_N=2'b11, SCAN_DONE=0, all debounce counters 0, debounced coin state 2'b11, coin pulse counters 0, coin synchronisers 2'b11.
- FSM, one state per cycle except where the state is held:
  - S_P1_SET: JSELECT=0. Hold for SETTLE_CYC cycles, then go to S_P1_SMP.
  - S_P1_SMP: JSELECT=0. Capture raw1 = JJOY & {2'b11, KBD_JOY} and the synchronised coin raw. Go to S_P2_SET.
  - S_P2_SET: JSELECT=1. Hold for SETTLE_CYC cycles, then go to S_P2_SMP.
  - S_P2_SMP: JSELECT=1. Capture raw2 = JJOY. Go to S_P1_SET.
  - Scan period = 2*(SETTLE_CYC+1) cycles. JSELECT is registered, and changes on the clock edge that enters S_P1_SET or S_P2_SET.
- Debounce rule, per bit, applied only on that player's SMP cycle:
  - If raw == out: counter <= 0.
  - Else if counter == DEB_SAMPLES-1: out <= raw and counter <= 0.
  - Else: counter increments.
  - A single differing sample resets the counter. Counters are 4 bits.
  - JOY1/JOY2 update on the clock edge that ends the SMP cycle.
- SCAN_DONE is high for the one cycle after S_P2_SMP, coincident with the first S_P1_SET cycle.
- Coins:
  - JCOIN passes through a 2-FF synchroniser every cycle.
  - The synchronised value is debounced with the same rule, sampled on S_P1_SMP only.
  - A debounced 1->0 transition on bit i sets COIN_N[i]=0 and loads a 16-bit counter with COIN_PULSE-1. The counter decrements each cycle; COIN_N[i] returns to 1 after exactly COIN_PULSE cycles low.
  - A new falling edge while the pulse is active is ignored: no retrigger, no extension.
  - Both coins are independent, and simultaneous presses produce simultaneous pulses.
- Held inputs: a JJOY bit held constant produces no further output changes. A stuck-low coin produces exactly one pulse until it is released (debounced high) and pressed again.
- Out-of-range parameters are unsupported. The implementation may assert on them in simulation.

Test Plan:
- Reset release, JJOY=8'hFF, JCOIN=2'b11, defaults -> JSELECT toggles with period 18 cycles (9 low, 9 high); JOY1=JOY2=8'hFF; COIN_N=2'b11; SCAN_DONE every 18 cycles.
- Bench drives JJOY=8'hFE while JSELECT=0 and 8'hFF while JSELECT=1, held for 3 scans -> JOY1 becomes 8'hFE after the 3rd P1 sample; JOY2 stays 8'hFF.
- P2 bit 7 low for 2 scans, high on the 3rd, then low for 3 scans -> no change until the 3rd consecutive low sample, then JOY2[7]=0.
- KBD_JOY=6'b111101 with JJOY=8'hFF -> JOY1=8'hFD after 3 scans; JOY2 unaffected.
- JCOIN[0] low for 10 scans, COIN_PULSE=16 -> COIN_N[0] low for exactly 16 cycles, once. Release, then press again -> a second 16-cycle pulse. Both coins pressed together -> simultaneous pulses.
- RESET asserted mid S_P2_SET with JOY1=8'hFE -> immediately JSELECT=0, JOY1=8'hFF, COIN_N=2'b11. After release, the full settle sequence restarts from S_P1_SET.

Source files
------------

// File: rtl/jamma_input_scanner.sv
// jamma_input_scanner
// Drives the JAMMA joystick splitter select, samples the shared JJOY bus once
// per player slot after a settle delay, debounces every bit, and turns
// debounced coin presses into fixed-width active-low coin pulses.
//
// Handshake note: this block has no valid/ready interfaces. SCAN_DONE is a
// plain one-cycle strobe, high in the first S_P1_SET cycle after a full
// P1+P2 scan has been applied to JOY1/JOY2.
module jamma_input_scanner #(
   parameter int SETTLE_CYC  = 8,
   parameter int DEB_SAMPLES = 3,
   parameter int COIN_PULSE  = 16
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] JJOY,
   input  logic [1:0] JCOIN,
   input  logic [5:0] KBD_JOY,
   output logic       JSELECT,
   output logic [7:0] JOY1,
   output logic [7:0] JOY2,
   output logic [1:0] COIN_N,
   output logic       SCAN_DONE
);

   typedef enum logic [1:0] {
      S_P1_SET = 2'd0,
      S_P1_SMP = 2'd1,
      S_P2_SET = 2'd2,
      S_P2_SMP = 2'd3
   } state_t;

   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [3:0]  DEB_LAST    = 4'(DEB_SAMPLES - 1);
   localparam logic [15:0] PULSE_LAST  = 16'(COIN_PULSE - 1);

   // Scan sequencer state
   state_t      state_q, state_d;
   logic [7:0]  settle_q, settle_d;
   logic        jsel_q, jsel_d;
   logic        done_q, done_d;

   // Player debounce state
   logic [7:0]       raw1, raw2;
   logic [7:0]       joy1_q, joy1_d;
   logic [7:0]       joy2_q, joy2_d;
   logic [7:0][3:0]  cnt1_q, cnt1_d;
   logic [7:0][3:0]  cnt2_q, cnt2_d;

   // Coin synchroniser, debounce and pulse state
   logic [1:0]        coin_s1_q, coin_s1_d;
   logic [1:0]        coin_s2_q, coin_s2_d;
   logic [1:0]        coin_deb_q, coin_deb_d;
   logic [1:0][3:0]   coin_cnt_q, coin_cnt_d;
   logic [1:0]        coin_n_q, coin_n_d;
   logic [1:0][15:0]  pulse_cnt_q, pulse_cnt_d;

   // Next-state for the select/settle/sample sequencer; JSELECT and SCAN_DONE
   // are computed one cycle early so they come straight from flops.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      jsel_d   = jsel_q;
      done_d   = 1'b0;
      case (state_q)
         S_P1_SET: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = 8'd0;
               state_d  = S_P1_SMP;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         S_P1_SMP: begin
            state_d = S_P2_SET;
            jsel_d  = 1'b1;
         end
         S_P2_SET: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = 8'd0;
               state_d  = S_P2_SMP;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         S_P2_SMP: begin
            state_d = S_P1_SET;
            jsel_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d  = S_P1_SET;
            settle_d = 8'd0;
            jsel_d   = 1'b0;
         end
      endcase
   end

   // Sequencer registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_P1_SET;
         settle_q <= 8'd0;
         jsel_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         jsel_q   <= jsel_d;
         done_q   <= done_d;
      end
   end

   // Player debounce: a bit only changes after DEB_SAMPLES consecutive
   // differing samples; any agreeing sample clears its counter.
   always_comb begin
      raw1   = JJOY & {2'b11, KBD_JOY};
      raw2   = JJOY;
      joy1_d = joy1_q;
      joy2_d = joy2_q;
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;
      if (state_q == S_P1_SMP) begin
         for (int i = 0; i < 8; i++) begin
            if (raw1[i] == joy1_q[i]) begin
               cnt1_d[i] = 4'd0;
            end else if (cnt1_q[i] == DEB_LAST) begin
               joy1_d[i] = raw1[i];
               cnt1_d[i] = 4'd0;
            end else begin
               cnt1_d[i] = cnt1_q[i] + 4'd1;
            end
         end
      end
      if (state_q == S_P2_SMP) begin
         for (int i = 0; i < 8; i++) begin
            if (raw2[i] == joy2_q[i]) begin
               cnt2_d[i] = 4'd0;
            end else if (cnt2_q[i] == DEB_LAST) begin
               joy2_d[i] = raw2[i];
               cnt2_d[i] = 4'd0;
            end else begin
               cnt2_d[i] = cnt2_q[i] + 4'd1;
            end
         end
      end
   end

   // Player debounce registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         joy1_q <= 8'hFF;
         joy2_q <= 8'hFF;
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         joy1_q <= joy1_d;
         joy2_q <= joy2_d;
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
      end
   end

   // Coin path: 2-FF synchroniser every cycle, debounce on the P1 sample slot,
   // and a non-retriggering pulse generator per coin.
   always_comb begin
      coin_s1_d   = JCOIN;
      coin_s2_d   = coin_s1_q;
      coin_deb_d  = coin_deb_q;
      coin_cnt_d  = coin_cnt_q;
      coin_n_d    = coin_n_q;
      pulse_cnt_d = pulse_cnt_q;
      if (state_q == S_P1_SMP) begin
         for (int i = 0; i < 2; i++) begin
            if (coin_s2_q[i] == coin_deb_q[i]) begin
               coin_cnt_d[i] = 4'd0;
            end else if (coin_cnt_q[i] == DEB_LAST) begin
               coin_deb_d[i] = coin_s2_q[i];
               coin_cnt_d[i] = 4'd0;
            end else begin
               coin_cnt_d[i] = coin_cnt_q[i] + 4'd1;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (!coin_n_q[i]) begin
            // Pulse running: count down, release after the last low cycle.
            if (pulse_cnt_q[i] == 16'd0) begin
               coin_n_d[i] = 1'b1;
            end else begin
               pulse_cnt_d[i] = pulse_cnt_q[i] - 16'd1;
            end
         end else if (coin_deb_q[i] && !coin_deb_d[i]) begin
            // Debounced press edge while idle starts a new pulse.
            coin_n_d[i]    = 1'b0;
            pulse_cnt_d[i] = PULSE_LAST;
         end
      end
   end

   // Coin registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         coin_s1_q   <= 2'b11;
         coin_s2_q   <= 2'b11;
         coin_deb_q  <= 2'b11;
         coin_cnt_q  <= '0;
         coin_n_q    <= 2'b11;
         pulse_cnt_q <= '0;
      end else begin
         coin_s1_q   <= coin_s1_d;
         coin_s2_q   <= coin_s2_d;
         coin_deb_q  <= coin_deb_d;
         coin_cnt_q  <= coin_cnt_d;
         coin_n_q    <= coin_n_d;
         pulse_cnt_q <= pulse_cnt_d;
      end
   end

   assign JSELECT   = jsel_q;
   assign JOY1      = joy1_q;
   assign JOY2      = joy2_q;
   assign COIN_N    = coin_n_q;
   assign SCAN_DONE = done_q;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Directed bench for jamma_input_scanner with default parameters.
// Cycle index cyc counts rising edges since reset release; cycle 0 is the
// first S_P1_SET cycle. With SETTLE_CYC=8 a scan is 18 cycles: P1 sample in
// cycle 18k+8, P2 sample in cycle 18k+17. A debounced update from a sample in
// cycle s becomes visible in cycle s+1.
module tb_jamma_input_scanner;

   logic       clk;
   logic       rst;
   logic [7:0] jjoy;
   logic [1:0] jcoin;
   logic [5:0] kbd;
   logic       jsel;
   logic [7:0] joy1;
   logic [7:0] joy2;
   logic [1:0] coin_n;
   logic       scan_done;

   logic [7:0] p1_val;
   logic [7:0] p2_val;

   int checks;
   int failures;
   int cyc;

   jamma_input_scanner dut (
      .CLK       (clk),
      .RESET     (rst),
      .JJOY      (jjoy),
      .JCOIN     (jcoin),
      .KBD_JOY   (kbd),
      .JSELECT   (jsel),
      .JOY1      (joy1),
      .JOY2      (joy2),
      .COIN_N    (coin_n),
      .SCAN_DONE (scan_done)
   );

   // Clock / reset-relative cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Splitter model: the board presents the selected player on JJOY
   assign jjoy = jsel ? p2_val : p1_val;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to the falling edge inside cycle t (bounded)
   task automatic goto_cyc(input int t);
      int g;
      g = 0;
      while (cyc < t && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != t) chk("cycle_reach", 32'(cyc), 32'(t));
   endtask

   initial begin
      int low0;
      int low1;
      int falls0;
      logic prev0;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      p1_val   = 8'hFF;
      p2_val   = 8'hFF;
      jcoin    = 2'b11;
      kbd      = 6'h3F;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_jsel", 32'(jsel), 32'd0);
      chk("rst_joy1", 32'(joy1), 32'hFF);
      chk("rst_joy2", 32'(joy2), 32'hFF);
      chk("rst_coin", 32'(coin_n), 32'h3);
      chk("rst_done", 32'(scan_done), 32'd0);
      rst = 1'b0;

      // Idle scanning: JSELECT 9 low / 9 high, SCAN_DONE at each scan start
      for (int c = 0; c < 36; c++) begin
         goto_cyc(c);
         chk("idle_jsel", 32'(jsel), ((c % 18) >= 9) ? 32'd1 : 32'd0);
         chk("idle_done", 32'(scan_done), ((c % 18) == 0 && c != 0) ? 32'd1 : 32'd0);
      end
      chk("idle_joy1", 32'(joy1), 32'hFF);
      chk("idle_joy2", 32'(joy2), 32'hFF);
      chk("idle_coin", 32'(coin_n), 32'h3);

      // P1 bit 0 low for 3 scans (samples at 44, 62, 80)
      goto_cyc(36);
      p1_val = 8'hFE;
      goto_cyc(62);
      chk("p1_two_samples", 32'(joy1), 32'hFF);
      goto_cyc(80);
      chk("p1_before_third", 32'(joy1), 32'hFF);
      goto_cyc(81);
      chk("p1_after_third", 32'(joy1), 32'hFE);
      chk("p2_untouched", 32'(joy2), 32'hFF);

      // P2 bit 7: low 2 samples (89,107), high (125), low 3 samples (143,161,179)
      p2_val = 8'h7F;
      goto_cyc(108);
      chk("p2_two_low", 32'(joy2), 32'hFF);
      p2_val = 8'hFF;
      goto_cyc(126);
      chk("p2_interrupted", 32'(joy2), 32'hFF);
      p2_val = 8'h7F;
      goto_cyc(179);
      chk("p2_before_third", 32'(joy2), 32'hFF);
      goto_cyc(180);
      chk("p2_after_third", 32'(joy2), 32'h7F);
      chk("p1_held", 32'(joy1), 32'hFE);

      // Keyboard merged into P1 (samples at 188, 206, 224)
      p1_val = 8'hFF;
      kbd    = 6'b111101;
      goto_cyc(224);
      chk("kbd_before", 32'(joy1), 32'hFE);
      goto_cyc(225);
      chk("kbd_after", 32'(joy1), 32'hFD);
      chk("kbd_p2", 32'(joy2), 32'h7F);

      // Coin 0 held low ~10 scans: one 16-cycle pulse at 279..294
      jcoin  = 2'b10;
      low0   = 0;
      low1   = 0;
      falls0 = 0;
      prev0  = coin_n[0];
      for (int c = 226; c <= 405; c++) begin
         goto_cyc(c);
         if (c == 278) chk("coin_pre", 32'(coin_n), 32'h3);
         if (c == 279) chk("coin_start", 32'(coin_n), 32'h2);
         if (c == 294) chk("coin_last", 32'(coin_n), 32'h2);
         if (c == 295) chk("coin_end", 32'(coin_n), 32'h3);
         if (!coin_n[0]) low0++;
         if (!coin_n[1]) low1++;
         if (prev0 && !coin_n[0]) falls0++;
         prev0 = coin_n[0];
      end
      chk("coin0_width", 32'(low0), 32'd16);
      chk("coin0_pulses", 32'(falls0), 32'd1);
      chk("coin1_idle", 32'(low1), 32'd0);

      // Release then press again: second pulse at 513..528
      goto_cyc(414);
      jcoin = 2'b11;
      goto_cyc(468);
      chk("coin_release_quiet", 32'(coin_n), 32'h3);
      jcoin = 2'b10;
      goto_cyc(512);
      chk("coin2_pre", 32'(coin_n), 32'h3);
      goto_cyc(513);
      chk("coin2_start", 32'(coin_n), 32'h2);
      goto_cyc(528);
      chk("coin2_last", 32'(coin_n), 32'h2);
      goto_cyc(529);
      chk("coin2_end", 32'(coin_n), 32'h3);

      // Both coins together: simultaneous pulses at 639..654
      goto_cyc(540);
      jcoin = 2'b11;
      goto_cyc(594);
      jcoin = 2'b00;
      goto_cyc(638);
      chk("both_pre", 32'(coin_n), 32'h3);
      goto_cyc(639);
      chk("both_start", 32'(coin_n), 32'h0);
      goto_cyc(654);
      chk("both_last", 32'(coin_n), 32'h0);
      goto_cyc(655);
      chk("both_end", 32'(coin_n), 32'h3);

      // JOY1 -> FE (samples 656, 674, 692), then reset mid S_P2_SET
      p1_val = 8'hFE;
      kbd    = 6'h3F;
      p2_val = 8'hFF;
      goto_cyc(692);
      chk("pre_rst_joy1_old", 32'(joy1), 32'hFD);
      goto_cyc(693);
      chk("pre_rst_joy1", 32'(joy1), 32'hFE);
      goto_cyc(696);
      chk("pre_rst_jsel", 32'(jsel), 32'd1);
      rst   = 1'b1;
      jcoin = 2'b11;
      #1;
      chk("midrst_jsel", 32'(jsel), 32'd0);
      chk("midrst_joy1", 32'(joy1), 32'hFF);
      chk("midrst_joy2", 32'(joy2), 32'hFF);
      chk("midrst_coin", 32'(coin_n), 32'h3);
      chk("midrst_done", 32'(scan_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Full settle sequence restarts from S_P1_SET
      for (int c = 0; c < 19; c++) begin
         goto_cyc(c);
         chk("restart_jsel", 32'(jsel), ((c % 18) >= 9) ? 32'd1 : 32'd0);
      end
      goto_cyc(44);
      chk("restart_joy1_pre", 32'(joy1), 32'hFF);
      goto_cyc(45);
      chk("restart_joy1", 32'(joy1), 32'hFE);
      chk("restart_coin", 32'(coin_n), 32'h3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
